// File: rtl/lock_code_tx.sv
// lock_code_tx
// Serial code transmitter driving the D input of a sequence-detecting lock.
// On an accepted start it captures a parallel code, sends a guard bit (1)
// followed by the code MSB-first, then watches the lock's L feedback for a
// bounded window. Timeouts trigger a resend of the captured code until the
// attempt budget is used up. One success or fail result per request.
//
// Ports:
//   clk      in   single clock, rising-edge
//   reset    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   code     in   [CODE_LEN-1:0] code, captured when start is accepted
//   L        in   unlock feedback, sampled only in WAIT
//   D        out  serial data to the lock, idles at 1
//   busy     out  high in GUARD, SEND and WAIT
//   done     out  one-cycle pulse in DONE
//   success  out  result flag, held until next accepted start
//   fail     out  result flag, held until next accepted start
module lock_code_tx #(
    parameter int unsigned CODE_LEN  = 3,
    parameter int unsigned TIMEOUT   = 4,
    parameter int unsigned MAX_TRIES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    input  logic                L,
    output logic                D,
    output logic                busy,
    output logic                done,
    output logic                success,
    output logic                fail
);

    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
    localparam int unsigned BW  = $clog2(CODE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] sh_q, sh_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [TRW-1:0]      tries_q, tries_d;
    logic                succ_q, succ_d;
    logic                fail_q, fail_d;
    logic [TW-1:0]       timer_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            code_q  <= '0;
            bit_q   <= '0;
            timer_q <= '0;
            tries_q <= '0;
            succ_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            code_q  <= code_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
            succ_q  <= succ_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        code_d    = code_q;
        bit_d     = bit_q;
        timer_d   = timer_q;
        tries_d   = tries_q;
        succ_d    = succ_q;
        fail_d    = fail_q;
        timer_inc = timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GUARD;
                    sh_d    = code;
                    code_d  = code;
                    tries_d = '0;
                    timer_d = '0;
                    succ_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_GUARD: begin
                state_d = S_SEND;
                bit_d   = '0;
            end
            S_SEND: begin
                sh_d  = sh_q << 1;
                bit_d = bit_q + BW'(1);
                if (bit_q == BW'(CODE_LEN - 1)) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                // L wins over a simultaneous timeout in the last WAIT cycle.
                if (L) begin
                    succ_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(TIMEOUT)) begin
                        tries_d = tries_q + TRW'(1);
                        if (int'(tries_q) + 1 < int'(MAX_TRIES)) begin
                            sh_d    = code_q;
                            timer_d = '0;
                            state_d = S_GUARD;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        D       = (state_q == S_SEND) ? sh_q[CODE_LEN-1] : 1'b1;
        busy    = (state_q == S_GUARD) || (state_q == S_SEND) || (state_q == S_WAIT);
        done    = (state_q == S_DONE);
        success = succ_q;
        fail    = fail_q;
    end

endmodule

// File: doc/lock_code_tx.md
# lock_code_tx

Serial code transmitter that drives the `D` input of the sequence-detecting lock FSM. When `start` is pulsed, it captures a parallel code and shifts it out MSB-first, one bit per clock, after a guard bit. It then watches the lock's `L` feedback for a bounded window and retries on timeout. The block sits on the key side of the lock link and reports a single success or failure result per request.

## Interface
- `CODE_LEN`, 3: code length in bits; must be ≥1.
- `TIMEOUT`, 4: WAIT cycles allowed per attempt for `L` to rise; must be ≥1.
- `MAX_TRIES`, 2: total attempts before reporting failure; must be ≥1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  request; sampled only in IDLE.
- `code`  in  CODE_LEN  code to send; captured on the edge that accepts `start`.
- `L`  in  1  unlock feedback from the lock; sampled only in WAIT.
- `D`  out  1  serial data to the lock; idles at 1.
- `busy`  out  1  high in GUARD, SEND and WAIT.
- `done`  out  1  one-cycle pulse in DONE.
- `success`  out  1  result flag; held until the next accepted `start`.
- `fail`  out  1  result flag; held until the next accepted `start`.

## Operation
- States:
  - IDLE: `D`=1.
  - GUARD: `D`=1 for 1 cycle.
  - SEND: CODE_LEN cycles; `D` = current code bit.
  - WAIT: up to TIMEOUT cycles; `D`=1.
  - DONE: 1 cycle, then IDLE.
- All outputs are Moore-decoded from registered state, shift register and flags. There is no combinational path from any input to any output.
- IDLE → GUARD when `start`=1. On that edge:
  - load the shift register with `code`;
  - clear `tries`, `success` and `fail`.
- GUARD → SEND. The guard bit is 1 so the lock parks in its initial state before the code.
- SEND:
  - Bit order is `code[CODE_LEN-1]` first and `code[0]` last.
  - Shift once per cycle.
  - Go to WAIT after CODE_LEN cycles. Clear the wait timer on entry.
- WAIT, at each edge:
  - If `L`=1: set `success`, go to DONE.
  - Else, when the timer reaches TIMEOUT:
    - increment `tries`;
    - if `tries`+1 < MAX_TRIES: reload the shift register from the captured code copy and go to GUARD;
    - otherwise: set `fail` and go to DONE.
- `L` is ignored outside WAIT, including when it is already high during GUARD or SEND.
- `start` is ignored outside IDLE, including during DONE.
- A new request's `code` may change after capture without effect; retries resend the captured value.
- Width rules:
  - `tries` is $clog2(MAX_TRIES+1) bits; the timer is $clog2(TIMEOUT+1) bits.
  - Neither counter wraps: each resets on GUARD entry (timer) or on accepted `start` (`tries`).
- `success` and `fail` are never high together.

## Timing
- Reset values: state IDLE, `D`=1, `busy`=0, `done`=0, `success`=0, `fail`=0, `tries`=0, timer=0, shift register=0.
- Reset mid-operation forces these values immediately and asynchronously. After release, the block stays in IDLE until a new `start`.
- Let E0 be the edge that accepts `start`:
  - cycle 1: GUARD;
  - cycles 2..CODE_LEN+1: SEND;
  - from cycle CODE_LEN+2: WAIT.
- Against the lock, `L` rises in the first WAIT cycle. `done` is therefore high in cycle CODE_LEN+3 (cycle 6 at defaults).
- A failed attempt lasts 1+CODE_LEN+TIMEOUT cycles.
- Worst-case `done` is in cycle MAX_TRIES·(1+CODE_LEN+TIMEOUT)+1 (cycle 17 at defaults).
- `L` seen high in the TIMEOUT-th WAIT cycle counts as success, not timeout.

## Test plan
- Paired with the lock FSM, `code`=3'b010, pulse `start`:
  - `D` reads 1,0,1,0 in cycles 1–4, then 1;
  - `done` and `success`=1 in cycle 6; `fail`=0.
- Paired with the lock, `code`=3'b011:
  - `L` never rises;
  - `D` shows two guard+code attempts;
  - `done` and `fail`=1 in cycle 17; `success`=0.
- Bench-driven `L`, raised in the 4th WAIT cycle of attempt 1:
  - `success`=1, `done` in cycle 9;
  - no GUARD re-entry.
- `start` re-pulsed during SEND and during DONE: ignored, no state change. A subsequent `start` in IDLE clears `success` on that edge.
- `reset`=0 in the 2nd SEND cycle:
  - `D`=1, `busy`=0 and all flags 0 without waiting for a clock edge;
  - after release, IDLE holds until `start`.
- Parameter sweep: CODE_LEN=1/TIMEOUT=1/MAX_TRIES=1 with `L`=0 → `fail` and `done` in cycle 4.
